// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/sub sequencer.
package bit_serial_add_ctrl_pkg;

   // Sequencer states: one READ/WRITE pair per bit position, LSB first.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Value of the sub input selecting each operation.
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_add_ctrl_fa.sv
// Registered full-adder slice: holds the running carry, the current sum bit
// and the carry into the MSB (needed later for signed overflow).
module bit_serial_fa (
   input  logic clk,
   input  logic rst,
   input  logic init_i,        // load carry with carry_init_i (start of op)
   input  logic carry_init_i,  // 1 for subtract (two's complement +1)
   input  logic sample_i,      // READ edge: fold operand bits into sum/carry
   input  logic msb_i,         // current bit is the MSB
   input  logic commit_i,      // WRITE edge: advance the running carry
   input  logic a_i,
   input  logic b_i,           // already inverted for subtract
   output logic sum_o,
   output logic carry_next_o,
   output logic cin_msb_o
);

   logic carry_q, sum_q, carry_next_q, cin_msb_q;

   // Operand bits are consumed directly into the sum/next-carry registers at
   // the READ edge, so the array may be overwritten (in-place) afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         carry_q      <= 1'b0;
         sum_q        <= 1'b0;
         carry_next_q <= 1'b0;
         cin_msb_q    <= 1'b0;
      end else begin
         if (init_i)
            carry_q <= carry_init_i;
         else if (commit_i)
            carry_q <= carry_next_q;
         if (sample_i) begin
            sum_q        <= a_i ^ b_i ^ carry_q;
            carry_next_q <= (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
            if (msb_i)
               cin_msb_q <= carry_q;
         end
      end
   end

   assign sum_o        = sum_q;
   assign carry_next_o = carry_next_q;
   assign cin_msb_o    = cin_msb_q;

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving array read/write wordlines.
// Each bit takes a READ cycle (operand wordlines) followed by a WRITE cycle
// (destination wordline plus result bit), LSB to MSB.
module bit_serial_add_ctrl
   import bit_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   output logic [WIDTH-1:0] a_rwl,
   output logic [WIDTH-1:0] b_rwl,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic [WIDTH-1:0] d_wwl,
   output logic             from_adder,
   output logic             busy,
   output logic             done,
   output logic             carry_out,
   output logic             overflow
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             sub_q, sub_d;
   logic [WIDTH-1:0] rd_wl_q, wr_wl_q, onehot_d;
   logic             busy_q, done_q, carry_out_q, overflow_q;
   logic             fa_init, fa_sample, fa_commit;
   logic             fa_sum, fa_carry_next, fa_cin_msb;
   logic             last_bit;

   assign last_bit = (idx_q == IDX_W'(WIDTH - 1));
   assign onehot_d = {{(WIDTH-1){1'b0}}, 1'b1} << idx_d;

   // State, index and latched opcode registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         sub_q   <= OP_ADD;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sub_q   <= sub_d;
      end
   end

   // Next-state logic and adder-slice strobes.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      sub_d     = sub_q;
      fa_init   = 1'b0;
      fa_sample = 1'b0;
      fa_commit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
               idx_d   = '0;
               sub_d   = sub;
               fa_init = 1'b1;
            end
         end
         ST_READ: begin
            fa_sample = 1'b1;
            state_d   = ST_WRITE;
         end
         ST_WRITE: begin
            fa_commit = 1'b1;
            if (last_bit) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Wordlines and status are registered from the next state so they are
   // glitch-free and line up exactly with the READ/WRITE cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_wl_q     <= '0;
         wr_wl_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rd_wl_q <= (state_d == ST_READ)  ? onehot_d : '0;
         wr_wl_q <= (state_d == ST_WRITE) ? onehot_d : '0;
         busy_q  <= (state_d == ST_READ) || (state_d == ST_WRITE);
         done_q  <= (state_d == ST_DONE);
         if (state_q == ST_WRITE && state_d == ST_DONE) begin
            carry_out_q <= fa_carry_next;
            overflow_q  <= fa_cin_msb ^ fa_carry_next;
         end
      end
   end

   bit_serial_fa u_fa (
      .clk          (clk),
      .rst          (rst),
      .init_i       (fa_init),
      .carry_init_i (sub == OP_SUB),
      .sample_i     (fa_sample),
      .msb_i        (last_bit),
      .commit_i     (fa_commit),
      .a_i          (a_bit),
      .b_i          (b_bit ^ (sub_q == OP_SUB)),
      .sum_o        (fa_sum),
      .carry_next_o (fa_carry_next),
      .cin_msb_o    (fa_cin_msb)
   );

   assign a_rwl      = rd_wl_q;
   assign b_rwl      = rd_wl_q;
   assign d_wwl      = wr_wl_q;
   assign from_adder = fa_sum;
   assign busy       = busy_q;
   assign done       = done_q;
   assign carry_out  = carry_out_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench: behavioural arrays answer the wordlines, results are
// compared with an arithmetic reference model.
module tb_bit_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, sub;
   logic [W-1:0] a_rwl, b_rwl, d_wwl;
   logic         a_bit, b_bit, from_adder, busy, done, carry_out, overflow;

   int total = 0;
   int bad   = 0;

   // behavioural arrays
   logic [W-1:0] A_mem, B_mem, D_mem;
   logic [W-1:0] ld_a, ld_b;
   logic         load_req = 1'b0;
   logic         inplace  = 1'b0;
   logic         chk_en   = 1'b0;

   always #5 clk = ~clk;

   bit_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub),
      .a_rwl(a_rwl), .b_rwl(b_rwl), .a_bit(a_bit), .b_bit(b_bit),
      .d_wwl(d_wwl), .from_adder(from_adder), .busy(busy), .done(done),
      .carry_out(carry_out), .overflow(overflow)
   );

   assign a_bit = |(a_rwl & A_mem);
   assign b_bit = |(b_rwl & B_mem);

   always @(posedge clk) begin
      if (load_req) begin
         A_mem = ld_a;
         B_mem = ld_b;
         D_mem = '0;
      end else begin
         for (int i = 0; i < W; i++)
            if (d_wwl[i]) begin
               if (inplace) A_mem[i] = from_adder;
               else         D_mem[i] = from_adder;
            end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if ((|a_rwl || |b_rwl) && |d_wwl) begin
            bad++;
            $display("FAIL protocol_rd_wr_overlap: rwl=%h wwl=%h required no overlap", a_rwl, d_wwl);
         end
         total++;
         if (!$onehot0(a_rwl) || !$onehot0(b_rwl) || !$onehot0(d_wwl) || a_rwl !== b_rwl) begin
            bad++;
            $display("FAIL protocol_onehot: a=%h b=%h d=%h required onehot0", a_rwl, b_rwl, d_wwl);
         end
      end
   end

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                 output logic [W-1:0] d, output bit c, output bit v);
      int sa, sb, r, u;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = s ? sa - sb : sa + sb;
      u  = s ? int'(a) - int'(b) : int'(a) + int'(b);
      d  = W'(u);
      c  = s ? (a >= b) : (u > 255);
      v  = (r > 127) || (r < -128);
   endfunction

   // Load arrays, start one op, observe until done (bounded).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input bit ip, input bit poke,
                         output logic [W-1:0] d, output bit c, output bit v,
                         output int done_at, output int busy_n);
      ld_a = a; ld_b = b; inplace = ip; load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      sub = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_at = 0; busy_n = 0;
      for (int n = 1; n <= 40; n++) begin
         if (poke && n == 5) begin start = 1'b1; sub = ~s; end
         if (poke && n == 6) start = 1'b0;
         if (n > 1) begin @(posedge clk); #1; end
         if (busy) busy_n++;
         if (done) begin done_at = n; break; end
      end
      start = 1'b0; sub = s;
      d = ip ? A_mem : D_mem;
      c = carry_out;
      v = overflow;
   endtask

   task automatic test_reset();
      total++;
      if ({a_rwl, b_rwl, d_wwl, from_adder, busy, done, carry_out, overflow} !== '0) begin
         bad++;
         $display("FAIL reset_state: got a=%h b=%h d=%h fa=%b busy=%b done=%b co=%b ov=%b required all 0",
                  a_rwl, b_rwl, d_wwl, from_adder, busy, done, carry_out, overflow);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] ta[5] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80};
      logic [W-1:0] tb[5] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01};
      bit           ts[5] = '{0, 0, 0, 1, 1};
      logic [W-1:0] d, ed;
      bit c, v, ec, ev;
      int dn, bn;
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb[i], ts[i], 1'b0, 1'b0, d, c, v, dn, bn);
         model(ta[i], tb[i], ts[i], ed, ec, ev);
         total++;
         if (d !== ed || c !== ec || v !== ev) begin
            bad++;
            $display("FAIL directed_%0d: got d=%h c=%b v=%b required d=%h c=%b v=%b", i, d, c, v, ed, ec, ev);
         end
         total++;
         if (dn != 2*W+1 || bn != 2*W) begin
            bad++;
            $display("FAIL latency_%0d: got done_at=%0d busy=%0d required %0d/%0d", i, dn, bn, 2*W+1, 2*W);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, d, ed;
      bit s, c, v, ec, ev;
      int dn, bn;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom); b = W'($urandom); s = bit'($urandom_range(0, 1));
         run_op(a, b, s, 1'b0, 1'b0, d, c, v, dn, bn);
         model(a, b, s, ed, ec, ev);
         total++;
         if (d !== ed || c !== ec || v !== ev || dn != 2*W+1) begin
            bad++;
            $display("FAIL random_%0d (%h %s %h): got d=%h c=%b v=%b t=%0d required d=%h c=%b v=%b t=%0d",
                     i, a, s ? "-" : "+", b, d, c, v, dn, ed, ec, ev, 2*W+1);
         end
      end
   endtask

   task automatic test_inplace();
      logic [W-1:0] d;
      bit c, v;
      int dn, bn;
      run_op(8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0, d, c, v, dn, bn);
      inplace = 1'b0;
      total++;
      if (d !== 8'h1E) begin
         bad++;
         $display("FAIL inplace: got %h required 1e", d);
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] d;
      bit c, v;
      int dn, bn;
      run_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b1, d, c, v, dn, bn);
      total++;
      if (d !== 8'h7F || c !== 1'b0 || v !== 1'b0 || dn != 2*W+1) begin
         bad++;
         $display("FAIL start_ignored: got d=%h c=%b v=%b t=%0d required d=7f c=0 v=0 t=%0d", d, c, v, dn, 2*W+1);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] d;
      bit c, v, seen;
      int dn, bn;
      ld_a = 8'hA5; ld_b = 8'h3C; inplace = 1'b0; load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         if (d_wwl === 8'h08) seen = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL reset_mid_reach_bit3: never saw write of bit 3");
      end
      rst = 1'b1;
      #1;
      total++;
      if (a_rwl !== '0 || b_rwl !== '0 || d_wwl !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_async: got a=%h b=%h d=%h busy=%b done=%b required all 0",
                  a_rwl, b_rwl, d_wwl, busy, done);
      end
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL reset_mid_no_done: got done pulse required none");
      end
      run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, d, c, v, dn, bn);
      total++;
      if (d !== 8'h03 || dn != 2*W+1) begin
         bad++;
         $display("FAIL reset_mid_recover: got d=%h t=%0d required d=03 t=%0d", d, dn, 2*W+1);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0;
      ld_a = '0; ld_b = '0;
      #12;
      test_reset();
      @(negedge clk); rst = 1'b0;
      chk_en = 1'b1;
      test_directed();
      test_random();
      test_inplace();
      test_start_ignored();
      test_reset_mid();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
